arbitro_interfaces: RTL

- Sequential arbiter that shares the single downstream code-forwarding path between two requesting interfaces, IE01 and IE02.
- Samples both request lines, picks a winner with round-robin on ties, and latches the winner's code.
- Presents the code downstream with a valid/ready handshake, then enforces a guard interval before re-arbitrating.
- Sits between the two interface blocks and the shared consumer of their codes.

---
 rtl/arbitro_pkg.sv | 18 +
 rtl/contador_guarda.sv | 30 +++
 rtl/arbitro_interfaces.sv | 118 +++++++++++
 3 files changed

// File: rtl/arbitro_pkg.sv
// Shared types for the two-interface code arbiter: FSM encoding, source ids, counter sizing.
package arbitro_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    localparam logic SRC_IE01 = 1'b0;
    localparam logic SRC_IE02 = 1'b1;

    // A zero-valued maximum still needs a one-bit counter.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/contador_guarda.sv
// Loadable down-counter with zero and "one left" flags; load has priority over decrement.
// Latency: flags reflect the registered count. No backpressure; saturates at zero.
module contador_guarda #(
    parameter int W = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero,
    output logic         o_last
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);
    assign o_last = (r_cnt == W'(1));

endmodule

// File: rtl/arbitro_interfaces.sv
// Round-robin arbiter forwarding IE01/IE02 codes over one valid/ready path, then a guard gap.
// Latency 1 cycle request-to-valid; code held until ready_in. Optional drop: ARBITRO_TIMEOUT_EN.
module arbitro_interfaces
    import arbitro_pkg::*;
#(
    parameter int CODE_W      = 8,
    parameter int GUARD_CYC   = 2,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_ie01,
    input  logic [CODE_W-1:0] code_ie01,
    input  logic              req_ie02,
    input  logic [CODE_W-1:0] code_ie02,
    output logic              gnt_ie01,
    output logic              gnt_ie02,
    output logic              sel,
    output logic [CODE_W-1:0] code_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic              busy,
    output logic              timeout_err
);

    localparam int GW = cnt_w(GUARD_CYC);
    localparam logic [GW-1:0] GUARD_LD = GW'(GUARD_CYC);

    state_t            r_state, w_state_nxt;
    logic              r_last, r_sel, r_first, r_to_err;
    logic [CODE_W-1:0] r_code;
    logic              w_any, w_pick, w_win, w_hs, w_to_fire, w_end;
    logic              w_g_zero, w_g_last;

    assign w_any  = req_ie01 | req_ie02;
    // On a tie the requester not served last wins.
    assign w_pick = (req_ie01 && req_ie02) ? ~r_last : (req_ie02 ? SRC_IE02 : SRC_IE01);
    assign w_win  = (r_state == ST_IDLE) && w_any;
    assign w_hs   = (r_state == ST_SEND) && ready_in;
    assign w_end  = w_hs | w_to_fire;

`ifdef ARBITRO_TIMEOUT_EN
    localparam int TW = cnt_w(TIMEOUT_CYC);
    logic w_t_zero, w_t_last;

    contador_guarda #(.W(TW)) u_cnt_timeout (
        .i_clk      (clk),
        .i_rst_n    (reset_n),
        .i_load     (w_win),
        .i_load_val (TW'(TIMEOUT_CYC)),
        .i_dec      (r_state == ST_SEND),
        .o_zero     (w_t_zero),
        .o_last     (w_t_last)
    );

    assign w_to_fire = (r_state == ST_SEND) && !ready_in && (w_t_last || w_t_zero);
`else
    // Timeout path absent; the parameter only remains visible on the interface.
    assign w_to_fire = (TIMEOUT_CYC < 1) & 1'b0;
`endif

    contador_guarda #(.W(GW)) u_cnt_guard (
        .i_clk      (clk),
        .i_rst_n    (reset_n),
        .i_load     (w_end),
        .i_load_val (GUARD_LD),
        .i_dec      (r_state == ST_GUARD),
        .o_zero     (w_g_zero),
        .o_last     (w_g_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_any) w_state_nxt = ST_SEND;
            ST_SEND:  if (w_end) w_state_nxt = (GUARD_CYC == 0) ? ST_IDLE : ST_GUARD;
            ST_GUARD: if (w_g_last || w_g_zero) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        valid_out   = (r_state == ST_SEND);
        busy        = (r_state != ST_IDLE);
        gnt_ie01    = valid_out && r_first && (r_sel == SRC_IE01);
        gnt_ie02    = valid_out && r_first && (r_sel == SRC_IE02);
        sel         = r_sel;
        code_out    = r_code;
        timeout_err = r_to_err;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last   <= SRC_IE02;
            r_sel    <= SRC_IE01;
            r_code   <= '0;
            r_first  <= 1'b0;
            r_to_err <= 1'b0;
        end else begin
            r_first  <= w_win;
            r_to_err <= w_to_fire;
            if (w_win) begin
                r_last <= w_pick;
                r_sel  <= w_pick;
                r_code <= (w_pick == SRC_IE02) ? code_ie02 : code_ie01;
            end
        end
    end

endmodule
